// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 register slice.
package axi4_pkg;

  // Per-channel slicing mode.
  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  // Burst type encodings.
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  // Response encodings.
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Occupancy of a full skid-buffer slice.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fsm_e;

  // Packed payload width of an AW/AR beat: id, addr, len, size, burst, lock, cache, prot.
  function automatic int addr_chan_width(input int id_w, input int addr_w, input int len_w);
    return id_w + addr_w + len_w + 3 + 2 + 1 + 4 + 3;
  endfunction

endpackage

// File: rtl/axi4_slice_chan.sv
// One valid/ready channel slice: bypass, forward register, or full skid buffer.
module axi4_slice_chan
  import axi4_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data
);

  generate
    if (MODE == SLICE_BYPASS) begin : g_bypass
      // Pure wires; clock and reset have no function here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dst_valid = src_valid;
      assign dst_data  = src_data;
      assign src_ready = dst_ready;

    end else if (MODE == SLICE_FWD) begin : g_fwd
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             load;

      // Ready passes combinationally from the downstream side when full.
      assign src_ready = !valid_reg || dst_ready;
      assign load      = src_valid && src_ready;
      assign dst_valid = valid_reg;
      assign dst_data  = data_reg;

      // Capture on source handshake; drop valid once consumed with nothing new.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (load) begin
          valid_reg <= 1'b1;
          data_reg  <= src_data;
        end else if (valid_reg && dst_ready) begin
          valid_reg <= 1'b0;
        end
      end

    end else begin : g_full
      fsm_e             state_reg, state_next;
      logic [WIDTH-1:0] main_reg, skid_reg;
      logic             ready_reg;
      logic             src_hs, dst_hs;
      logic             load_main, load_skid, move_skid;

      // Ready is a flop, so downstream ready never reaches upstream ready.
      assign src_ready = ready_reg;
      assign dst_valid = (state_reg != EMPTY);
      assign dst_data  = main_reg;
      assign src_hs    = src_valid && ready_reg;
      assign dst_hs    = (state_reg != EMPTY) && dst_ready;

      // Occupancy state register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= EMPTY;
        end else begin
          state_reg <= state_next;
        end
      end

      // Next occupancy and data-path steering; skid always drains before main reloads.
      always_comb begin
        state_next = state_reg;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state_reg)
          EMPTY: begin
            if (src_hs) begin
              state_next = ONE;
              load_main  = 1'b1;
            end
          end
          ONE: begin
            if (src_hs && !dst_hs) begin
              state_next = TWO;
              load_skid  = 1'b1;
            end else if (!src_hs && dst_hs) begin
              state_next = EMPTY;
            end else if (src_hs && dst_hs) begin
              load_main = 1'b1;
            end
          end
          TWO: begin
            if (dst_hs) begin
              state_next = ONE;
              move_skid  = 1'b1;
            end
          end
          default: state_next = EMPTY;
        endcase
      end

      // Payload registers and registered upstream ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_reg  <= '0;
          skid_reg  <= '0;
          ready_reg <= 1'b1;
        end else begin
          if (load_main) begin
            main_reg <= src_data;
          end else if (move_skid) begin
            main_reg <= skid_reg;
          end
          if (load_skid) begin
            skid_reg <= src_data;
          end
          ready_reg <= (state_next != TWO);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: five independent channel slices between s-side master and m-side slave.
module axi4_reg_slice
  import axi4_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter int          LEN_WIDTH  = 8,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FULL,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // upstream AW
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [LEN_WIDTH-1:0]  s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awlock,
  input  logic [3:0]            s_awcache,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  // upstream W
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  // upstream B
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // upstream AR
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [LEN_WIDTH-1:0]  s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arlock,
  input  logic [3:0]            s_arcache,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  // upstream R
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // downstream AW
  output logic [ID_WIDTH-1:0]   m_awid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [LEN_WIDTH-1:0]  m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awlock,
  output logic [3:0]            m_awcache,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // downstream W
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // downstream B
  input  logic [ID_WIDTH-1:0]   m_bid,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  // downstream AR
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [LEN_WIDTH-1:0]  m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arlock,
  output logic [3:0]            m_arcache,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // downstream R
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam int AX_W = addr_chan_width(ID_WIDTH, ADDR_WIDTH, LEN_WIDTH);
  localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int B_W  = ID_WIDTH + 2;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

  logic [AX_W-1:0] aw_src, aw_dst, ar_src, ar_dst;
  logic [W_W-1:0]  w_src, w_dst;
  logic [B_W-1:0]  b_src, b_dst;
  logic [R_W-1:0]  r_src, r_dst;

  // Pack / unpack each channel; field order is opaque to the slice itself.
  assign aw_src = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot};
  assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} = aw_dst;
  assign w_src  = {s_wdata, s_wstrb, s_wlast};
  assign {m_wdata, m_wstrb, m_wlast} = w_dst;
  assign b_src  = {m_bid, m_bresp};
  assign {s_bid, s_bresp} = b_dst;
  assign ar_src = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot};
  assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} = ar_dst;
  assign r_src  = {m_rid, m_rdata, m_rresp, m_rlast};
  assign {s_rid, s_rdata, s_rresp, s_rlast} = r_dst;

  axi4_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_awvalid), .src_ready(s_awready), .src_data(aw_src),
    .dst_valid(m_awvalid), .dst_ready(m_awready), .dst_data(aw_dst)
  );

  axi4_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_wvalid), .src_ready(s_wready), .src_data(w_src),
    .dst_valid(m_wvalid), .dst_ready(m_wready), .dst_data(w_dst)
  );

  // Backward channel: source is the m-side slave.
  axi4_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(m_bvalid), .src_ready(m_bready), .src_data(b_src),
    .dst_valid(s_bvalid), .dst_ready(s_bready), .dst_data(b_dst)
  );

  axi4_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_arvalid), .src_ready(s_arready), .src_data(ar_src),
    .dst_valid(m_arvalid), .dst_ready(m_arready), .dst_data(ar_dst)
  );

  // Backward channel: source is the m-side slave.
  axi4_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(m_rvalid), .src_ready(m_rready), .src_data(r_src),
    .dst_valid(s_rvalid), .dst_ready(s_rready), .dst_data(r_dst)
  );

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Scoreboard bench for axi4_reg_slice: AR in bypass, B in forward-register, others full.
module tb_axi4_reg_slice;
  import axi4_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
  logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
  logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
  logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst;
  logic        s_awlock, s_arlock, m_awlock, m_arlock;
  logic [3:0]  s_awcache, s_arcache, m_awcache, m_arcache;
  logic        s_awvalid, s_awready, m_awvalid, m_awready;
  logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
  logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
  logic        s_bvalid, s_bready, m_bvalid, m_bready;
  logic        s_arvalid, s_arready, m_arvalid, m_arready;
  logic        s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;

  int vectors = 0;
  int miscompares = 0;
  int r_pops = 0;
  logic [63:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];

  always #5 aclk = ~aclk;

  axi4_reg_slice #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8),
    .AW_MODE(SLICE_FULL), .W_MODE(SLICE_FULL), .B_MODE(SLICE_FWD),
    .AR_MODE(SLICE_BYPASS), .R_MODE(SLICE_FULL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic extra(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected beat %h required none (t=%0t)", name, act, $time);
  endtask

  // Monitors: pop and compare on every handshake at each destination side.
  always @(negedge aclk) begin
    if (aresetn && m_awvalid && m_awready) begin
      if (aw_q.size() == 0) extra("aw_extra", 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot}));
      else check("aw_beat", 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot}), aw_q.pop_front());
    end
    if (aresetn && m_wvalid && m_wready) begin
      if (w_q.size() == 0) extra("w_extra", 64'({m_wdata, m_wstrb, m_wlast}));
      else check("w_beat", 64'({m_wdata, m_wstrb, m_wlast}), w_q.pop_front());
    end
    if (aresetn && m_arvalid && m_arready) begin
      if (ar_q.size() == 0) extra("ar_extra", 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}));
      else check("ar_beat", 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}), ar_q.pop_front());
    end
    if (aresetn && s_bvalid && s_bready) begin
      if (b_q.size() == 0) extra("b_extra", 64'({s_bid, s_bresp}));
      else check("b_beat", 64'({s_bid, s_bresp}), b_q.pop_front());
    end
    if (aresetn && s_rvalid && s_rready) begin
      r_pops++;
      if (r_q.size() == 0) extra("r_extra", 64'({s_rid, s_rdata, s_rresp, s_rlast}));
      else check("r_beat", 64'({s_rid, s_rdata, s_rresp, s_rlast}), r_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    logic hs;
    aresetn = 1'b0;
    {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awvalid} = '0;
    {s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready} = '0;
    {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arvalid} = '0;
    s_rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    {m_bid, m_bresp, m_bvalid} = '0;
    {m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;

    // Reset values, sampled between edges while reset is held.
    #12;
    check("rst_m_awvalid", 64'(m_awvalid), 64'(0));
    check("rst_m_wvalid",  64'(m_wvalid),  64'(0));
    check("rst_s_bvalid",  64'(s_bvalid),  64'(0));
    check("rst_s_rvalid",  64'(s_rvalid),  64'(0));
    check("rst_m_arvalid", 64'(m_arvalid), 64'(0));
    check("rst_s_awready", 64'(s_awready), 64'(1));
    check("rst_s_wready",  64'(s_wready),  64'(1));
    check("rst_m_rready",  64'(m_rready),  64'(1));
    check("rst_m_bready",  64'(m_bready),  64'(1));
    check("rst_m_awaddr",  64'(m_awaddr),  64'(0));
    check("rst_s_rdata",   64'(s_rdata),   64'(0));
    #10 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Reset mid-burst: fill AW skid while downstream stalls, then reset.
    s_awvalid = 1'b1; s_awid = 4'h1; s_awaddr = 32'hDEAD_0000;
    @(posedge aclk); #1;
    check("aw_one_ready", 64'(s_awready), 64'(1));
    s_awaddr = 32'hDEAD_0010;
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
    check("aw_two_ready", 64'(s_awready), 64'(0));
    check("aw_two_valid", 64'(m_awvalid), 64'(1));
    check("aw_two_addr",  64'(m_awaddr),  64'(32'hDEAD_0000));
    aresetn = 1'b0;
    #1;
    check("aw_async_valid", 64'(m_awvalid), 64'(0));
    check("aw_async_ready", 64'(s_awready), 64'(1));
    check("aw_async_addr",  64'(m_awaddr),  64'(0));
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("aw_post_ready", 64'(s_awready), 64'(1));
    check("aw_post_valid", 64'(m_awvalid), 64'(0));

    // Streaming 4-beat write with AW held stalled downstream.
    m_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        s_awvalid = 1'b1; s_awid = 4'h2; s_awaddr = 32'h0000_2000; s_awlen = 8'd3;
        s_awsize = 3'd2; s_awburst = INCR; s_awlock = 1'b0; s_awcache = 4'h3; s_awprot = 3'd0;
        aw_q.push_back(64'({4'h2, 32'h0000_2000, 8'd3, 3'd2, INCR, 1'b0, 4'h3, 3'd0}));
      end else begin
        s_awvalid = 1'b0;
      end
      s_wvalid = 1'b1; s_wdata = 32'h11 * (i + 1); s_wstrb = 4'hF; s_wlast = (i == 3);
      check("w_src_ready", 64'(s_wready), 64'(1));
      w_q.push_back(64'({32'h11 * (i + 1), 4'hF, (i == 3)}));
      @(posedge aclk); #1;
      check("w_lat_valid", 64'(m_wvalid), 64'(1));
      check("w_lat_data",  64'(m_wdata),  64'(32'h11 * (i + 1)));
      check("w_lat_last",  64'(m_wlast),  64'(i == 3));
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_awvalid = 1'b0;
    @(posedge aclk); #1;
    check("w_idle_valid",  64'(m_wvalid),  64'(0));
    check("aw_hold_valid", 64'(m_awvalid), 64'(1));
    check("aw_hold_addr",  64'(m_awaddr),  64'(32'h0000_2000));

    // AR bypass at full rate while AW is still stalled.
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_arvalid = 1'b1; s_arid = 4'(i); s_araddr = 32'h1000 + 32'(16 * i);
      s_arlen = 8'd0; s_arsize = 3'd2; s_arburst = FIXED; s_arlock = 1'b0; s_arcache = 4'h0; s_arprot = 3'd1;
      #1;
      check("ar_same_cycle_addr", 64'(m_araddr), 64'(32'h1000 + 32'(16 * i)));
      check("ar_stream_ready", 64'(s_arready), 64'(1));
      ar_q.push_back(64'({4'(i), 32'h1000 + 32'(16 * i), 8'd0, 3'd2, FIXED, 1'b0, 4'h0, 3'd1}));
      @(posedge aclk); #1;
    end
    s_arid = 4'h7; s_araddr = 32'h1000;
    m_arready = 1'b0;
    #1;
    check("ar_bypass_valid", 64'(m_arvalid), 64'(1));
    check("ar_bypass_addr",  64'(m_araddr),  64'(32'h1000));
    check("ar_ready_mirror0", 64'(s_arready), 64'(0));
    m_arready = 1'b1;
    #1;
    check("ar_ready_mirror1", 64'(s_arready), 64'(1));
    ar_q.push_back(64'({4'h7, 32'h1000, 8'd0, 3'd2, FIXED, 1'b0, 4'h0, 3'd1}));
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
    check("aw_still_stalled", 64'(m_awvalid), 64'(1));

    // Release AW: only the post-reset beat may come out.
    m_awready = 1'b1;
    @(posedge aclk); #1;
    check("aw_drained", 64'(m_awvalid), 64'(0));

    // R backpressure: downstream stalls for three cycles while the source streams.
    k = 0; c = 0;
    while (k < 4 && c < 20) begin
      m_rvalid = 1'b1; m_rid = 4'h5; m_rdata = 32'hA0 + 32'(k); m_rresp = OKAY; m_rlast = (k == 3);
      s_rready = (c >= 3);
      if (c == 1) check("r_ready_before_drop", 64'(m_rready), 64'(1));
      if (c == 2) check("r_ready_drop", 64'(m_rready), 64'(0));
      @(negedge aclk);
      hs = m_rready;
      if (hs) r_q.push_back(64'({4'h5, 32'hA0 + 32'(k), OKAY, (k == 3)}));
      @(posedge aclk); #1;
      if (hs) k++;
      c++;
    end
    check("r_src_beats", 64'(k), 64'(4));
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("r_delivered", 64'(r_pops), 64'(4));

    // B forward register: fill, then toggle upstream ready.
    m_bvalid = 1'b1; m_bid = 4'h3; m_bresp = SLVERR; s_bready = 1'b0;
    #1;
    check("b_empty_ready", 64'(m_bready), 64'(1));
    b_q.push_back(64'({4'h3, SLVERR}));
    @(posedge aclk); #1;
    m_bvalid = 1'b0;
    check("b_full_valid", 64'(s_bvalid), 64'(1));
    check("b_full_bid",   64'(s_bid),    64'(4'h3));
    check("b_full_bresp", 64'(s_bresp),  64'(SLVERR));
    check("b_full_ready", 64'(m_bready), 64'(0));
    s_bready = 1'b1;
    #1;
    check("b_ready_follow1", 64'(m_bready), 64'(1));
    s_bready = 1'b0;
    #1;
    check("b_ready_follow0", 64'(m_bready), 64'(0));
    s_bready = 1'b1;
    @(posedge aclk); #1;
    check("b_drained", 64'(s_bvalid), 64'(0));

    repeat (3) @(posedge aclk);
    #1;
    check("aw_q_empty", 64'(aw_q.size()), 64'(0));
    check("w_q_empty",  64'(w_q.size()),  64'(0));
    check("ar_q_empty", 64'(ar_q.size()), 64'(0));
    check("b_q_empty",  64'(b_q.size()),  64'(0));
    check("r_q_empty",  64'(r_q.size()),  64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
